// File: rtl/ucsbece154a_rf_wb.sv
// Register file write-side merge: ALU results take the write port first,
// buffered long-latency results drain from a FIFO, and a scoreboard tracks pending destinations.
module ucsbece154a_rf_wb #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rstn_i,
    input  logic          alu_valid_i,
    input  logic [4:0]    alu_rd_i,
    input  logic [31:0]   alu_data_i,
    input  logic          lsu_valid_i,
    output logic          lsu_ready_o,
    input  logic [4:0]    lsu_rd_i,
    input  logic [31:0]   lsu_data_i,
    input  logic          issue_i,
    input  logic [4:0]    issue_rd_i,
    input  logic [4:0]    a1_i,
    input  logic [4:0]    a2_i,
    output logic          busy1_o,
    output logic          busy2_o,
    output logic          we3_o,
    output logic [4:0]    a3_o,
    output logic [31:0]   wd3_o,
    output logic [AW:0]   count_o
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [4:0]    mem_rd_q   [DEPTH];
    logic [4:0]    mem_rd_d   [DEPTH];
    logic [31:0]   mem_data_q [DEPTH];
    logic [31:0]   mem_data_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   busy_q, busy_d;
    logic          we3_q, we3_d;
    logic [4:0]    a3_q, a3_d;
    logic [31:0]   wd3_q, wd3_d;

    logic          push;
    logic          pop;
    logic [4:0]    head_rd;
    logic [31:0]   head_data;

    // LSU handshake: an entry transfers on the edge where lsu_valid_i && lsu_ready_o;
    // ready depends only on registered occupancy and is held low during reset.
    assign lsu_ready_o = rstn_i && (count_q != FULL);

    assign head_rd   = mem_rd_q[rd_ptr_q];
    assign head_data = mem_data_q[rd_ptr_q];
    assign push      = lsu_valid_i && lsu_ready_o;
    assign pop       = !alu_valid_i && (count_q != '0);

    always_comb begin
        mem_rd_d   = mem_rd_q;
        mem_data_d = mem_data_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            mem_rd_d[wr_ptr_q]   = lsu_rd_i;
            mem_data_d[wr_ptr_q] = lsu_data_i;
            wr_ptr_d             = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // ALU has strict priority; an idle port keeps the last address/data.
    always_comb begin
        we3_d = 1'b0;
        a3_d  = a3_q;
        wd3_d = wd3_q;
        if (alu_valid_i) begin
            we3_d = (alu_rd_i != 5'd0);
            a3_d  = alu_rd_i;
            wd3_d = alu_data_i;
        end else if (pop) begin
            we3_d = (head_rd != 5'd0);
            a3_d  = head_rd;
            wd3_d = head_data;
        end
    end

    // Clear is applied before set so a same-cycle issue keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        if (pop) begin
            busy_d[head_rd] = 1'b0;
        end
        if (issue_i) begin
            busy_d[issue_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_rd_q[i]   <= '0;
                mem_data_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= '0;
            we3_q    <= 1'b0;
            a3_q     <= '0;
            wd3_q    <= '0;
        end else begin
            mem_rd_q   <= mem_rd_d;
            mem_data_q <= mem_data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            we3_q      <= we3_d;
            a3_q       <= a3_d;
            wd3_q      <= wd3_d;
        end
    end

    assign busy1_o = busy_q[a1_i];
    assign busy2_o = busy_q[a2_i];
    assign we3_o   = we3_q;
    assign a3_o    = a3_q;
    assign wd3_o   = wd3_q;
    assign count_o = count_q;

endmodule
